mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the CPU data port and the data RAM. Accesses below `g_IO_BASE` pass straight through to the RAM. Accesses in the 8-word I/O window at `g_IO_BASE` are served by the bridge itself: an LED output register, synchronised switches, debounced buttons with sticky edge flags, and a free-running tick counter. It replaces direct LED, switch and button wiring at the top level and lets software control all board I/O.

---
 rtl/mmio_bridge.sv | 135 +++++++++++++
 tb/tb_mmio_bridge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// CPU-to-data-RAM bridge with an 8-word I/O window: LED register, synchronised
// switches, debounced buttons with sticky rising-edge flags, and a tick counter.
module mmio_bridge #(
  parameter int                  g_WORD      = 9,
  parameter int                  g_ADDR      = 11,
  parameter int                  g_N_LED     = 8,
  parameter int                  g_N_BTN     = 5,
  parameter int                  g_N_SW      = 8,
  parameter logic [g_ADDR-1:0]   g_IO_BASE   = 11'h7F8,
  parameter int                  g_DB_CYCLES = 16,
  parameter logic [g_N_LED-1:0]  g_LED_RESET = 8'h99
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [g_ADDR-1:0]  i_addr,
  input  logic [g_WORD-1:0]  i_wdata,
  output logic [g_WORD-1:0]  o_rdata,
  output logic               o_ram_en,
  output logic               o_ram_we,
  output logic               o_ram_re,
  output logic [g_ADDR-1:0]  o_ram_addr,
  output logic [g_WORD-1:0]  o_ram_wdata,
  input  logic [g_WORD-1:0]  i_ram_rdata,
  output logic [g_N_LED-1:0] o_led,
  input  logic [g_N_BTN-1:0] i_btn,
  input  logic [g_N_SW-1:0]  i_sw
);

  localparam int             CW      = $clog2(g_DB_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(g_DB_CYCLES - 1);

  localparam logic [2:0] OFF_LED  = 3'd0;
  localparam logic [2:0] OFF_SW   = 3'd1;
  localparam logic [2:0] OFF_BTN  = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_TICK = 3'd4;

  logic              io_hit, io_we, io_rd;
  logic [2:0]        off;

  logic [g_N_LED-1:0] led_q, led_d;
  logic [g_N_SW-1:0]  sw_m_q, sw_q;
  logic [g_N_BTN-1:0] btn_m_q, btn_s_q;
  logic [g_N_BTN-1:0] lvl_q, lvl_d;
  logic [g_N_BTN-1:0] edge_q, edge_d, edge_clr;
  logic [g_WORD-1:0]  tick_q;
  logic               sel_io_q;
  logic [g_WORD-1:0]  io_rdata_q, io_val;

  assign io_hit = (i_addr[g_ADDR-1:3] == g_IO_BASE[g_ADDR-1:3]);
  assign off    = i_addr[2:0];
  assign io_we  = i_en & i_we & io_hit;
  assign io_rd  = i_en & i_re;

  assign o_ram_en    = i_en & ~io_hit;
  assign o_ram_we    = i_we & o_ram_en;
  assign o_ram_re    = i_re & o_ram_en;
  assign o_ram_addr  = i_addr;
  assign o_ram_wdata = i_wdata;

  // Per-button debounce: count cycles the synchronised input disagrees with
  // the level; flip the level once it has disagreed g_DB_CYCLES times in a row.
  for (genvar b = 0; b < g_N_BTN; b++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_nxt;

    always_comb begin
      cnt_d   = '0;
      lvl_nxt = lvl_q[b];
      if (btn_s_q[b] != lvl_q[b]) begin
        if (cnt_q == DB_LAST) lvl_nxt = ~lvl_q[b];
        else                  cnt_d   = cnt_q + 1'b1;
      end
    end

    assign lvl_d[b] = lvl_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  assign edge_clr = (io_we && off == OFF_EDGE) ? i_wdata[g_N_BTN-1:0] : '0;
  // Set term applied after the clear so a coincident rising edge wins.
  assign edge_d   = (edge_q & ~edge_clr) | (lvl_d & ~lvl_q);
  assign led_d    = (io_we && off == OFF_LED) ? i_wdata[g_N_LED-1:0] : led_q;

  always_comb begin
    io_val = '0;
    case (off)
      OFF_LED:  io_val[g_N_LED-1:0] = led_q;
      OFF_SW:   io_val[g_N_SW-1:0]  = sw_q;
      OFF_BTN:  io_val[g_N_BTN-1:0] = lvl_q;
      OFF_EDGE: io_val[g_N_BTN-1:0] = edge_q;
      OFF_TICK: io_val              = tick_q;
      default:  io_val              = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q      <= g_LED_RESET;
      sw_m_q     <= '0;
      sw_q       <= '0;
      btn_m_q    <= '0;
      btn_s_q    <= '0;
      lvl_q      <= '0;
      edge_q     <= '0;
      tick_q     <= '0;
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      sw_m_q  <= i_sw;
      sw_q    <= sw_m_q;
      btn_m_q <= i_btn;
      btn_s_q <= btn_m_q;
      lvl_q   <= lvl_d;
      edge_q  <= edge_d;
      tick_q  <= tick_q + 1'b1;
      if (io_rd) begin
        sel_io_q <= io_hit;
        if (io_hit) io_rdata_q <= io_val;
      end
    end
  end

  assign o_rdata = sel_io_q ? io_rdata_q : i_ram_rdata;
  assign o_led   = led_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a small synchronous RAM model.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        i_rst, i_en, i_we, i_re;
  logic [10:0] i_addr;
  logic [8:0]  i_wdata, o_rdata, o_ram_wdata, ram_rdata;
  logic        o_ram_en, o_ram_we, o_ram_re;
  logic [10:0] o_ram_addr;
  logic [7:0]  o_led;
  logic [4:0]  i_btn;
  logic [7:0]  i_sw;

  int errors = 0;
  int checks = 0;

  logic [8:0] mem [0:2047];

  always #5 clk = ~clk;

  mmio_bridge dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_we(i_we), .i_re(i_re),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_re(o_ram_re),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .o_led(o_led), .i_btn(i_btn), .i_sw(i_sw)
  );

  always @(posedge clk) begin
    if (o_ram_en && o_ram_re) ram_rdata <= mem[o_ram_addr];
    if (o_ram_en && o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    i_en = 1'b0; i_we = 1'b0; i_re = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a);
    i_en = 1'b1; i_re = 1'b1; i_we = 1'b0; i_addr = a;
    cyc();
    idle();
  endtask

  task automatic wr(input logic [10:0] a, input logic [8:0] d);
    i_en = 1'b1; i_we = 1'b1; i_re = 1'b0; i_addr = a; i_wdata = d;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b1; i_re = 1'b1; i_we = 1'b0;
    i_addr = 11'd5; i_wdata = 9'h1FF;
    repeat (3) cyc();
    checks++;
    if (o_led !== 8'h99) begin errors++; $display("FAIL reset_led: got %h exp 99", o_led); end
    checks++;
    if (o_rdata !== 9'h1AB) begin errors++; $display("FAIL reset_rdata: got %h exp 1ab", o_rdata); end
    // Release together with the first read; TICK is sampled after two counting edges.
    i_rst = 1'b0; i_addr = 11'h7FA;
    cyc();
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL reset_btn: got %h exp 000", o_rdata); end
    i_addr = 11'h7FB;
    cyc();
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL reset_edge: got %h exp 000", o_rdata); end
    i_addr = 11'h7FC;
    cyc();
    checks++;
    if (o_rdata !== 9'h002) begin errors++; $display("FAIL reset_tick: got %h exp 002", o_rdata); end
    idle();
  endtask

  task automatic test_window();
    i_en = 1'b1; i_we = 1'b1; i_re = 1'b0; i_addr = 11'h7F8; i_wdata = 9'h155;
    #1;
    checks++;
    if (o_ram_en !== 1'b0) begin errors++; $display("FAIL win_wr_ramen: got %b exp 0", o_ram_en); end
    cyc();
    checks++;
    if (o_led !== 8'h55) begin errors++; $display("FAIL win_led: got %h exp 55", o_led); end
    i_we = 1'b0; i_re = 1'b1;
    #1;
    checks++;
    if (o_ram_en !== 1'b0) begin errors++; $display("FAIL win_rd_ramen: got %b exp 0", o_ram_en); end
    cyc();
    idle();
    checks++;
    if (o_rdata !== 9'h055) begin errors++; $display("FAIL win_rdback: got %h exp 055", o_rdata); end
    i_en = 1'b1; i_we = 1'b1; i_addr = 11'h7F7; i_wdata = 9'h0AA;
    #1;
    checks++;
    if ({o_ram_en, o_ram_we, o_ram_re} !== 3'b110) begin
      errors++; $display("FAIL win_ram_strobes: got %b exp 110", {o_ram_en, o_ram_we, o_ram_re});
    end
    cyc();
    idle();
    checks++;
    if (o_led !== 8'h55) begin errors++; $display("FAIL win_led_hold: got %h exp 55", o_led); end
    checks++;
    if (mem[11'h7F7] !== 9'h0AA) begin errors++; $display("FAIL win_ram_wr: got %h exp 0aa", mem[11'h7F7]); end
    wr(11'h7FD, 9'h1FF);
    rd(11'h7FD);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL win_off5: got %h exp 000", o_rdata); end
  endtask

  task automatic test_debounce();
    int first;
    i_btn = 5'b00010;
    repeat (10) cyc();
    i_btn = 5'b00000;
    repeat (25) cyc();
    rd(11'h7FA);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL db_short_btn: got %h exp 000", o_rdata); end
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL db_short_edge: got %h exp 000", o_rdata); end

    // Level flips on edge 18 after the input change; a read on edge k returns the
    // level left by edge k-1, so the first read showing it is on edge 19.
    first = 0;
    i_btn = 5'b00010;
    i_en = 1'b1; i_re = 1'b1; i_we = 1'b0; i_addr = 11'h7FA;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (o_rdata[1] && first == 0) first = k;
    end
    idle();
    i_btn = 5'b00000;
    checks++;
    if (first !== 19) begin errors++; $display("FAIL db_latency: got %0d exp 19", first); end
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h002) begin errors++; $display("FAIL db_edge_set: got %h exp 002", o_rdata); end
    repeat (30) cyc();
    rd(11'h7FA);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL db_release: got %h exp 000", o_rdata); end
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h002) begin errors++; $display("FAIL db_fall_no_edge: got %h exp 002", o_rdata); end
  endtask

  task automatic test_edge_race();
    wr(11'h7FB, 9'h002);
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL race_preclear: got %h exp 000", o_rdata); end
    i_btn = 5'b00010;
    repeat (17) cyc();
    wr(11'h7FB, 9'h002);
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h002) begin errors++; $display("FAIL race_set_wins: got %h exp 002", o_rdata); end
    rd(11'h7FA);
    checks++;
    if (o_rdata !== 9'h002) begin errors++; $display("FAIL race_level: got %h exp 002", o_rdata); end
    wr(11'h7FB, 9'h002);
    rd(11'h7FB);
    checks++;
    if (o_rdata !== 9'h000) begin errors++; $display("FAIL race_clear: got %h exp 000", o_rdata); end
    i_btn = 5'b00000;
    repeat (25) cyc();
  endtask

  task automatic test_back_to_back();
    i_sw = 8'h3C;
    repeat (3) cyc();
    i_en = 1'b1; i_re = 1'b1; i_we = 1'b0; i_addr = 11'd5;
    cyc();
    checks++;
    if (o_rdata !== 9'h1AB) begin errors++; $display("FAIL b2b_ram: got %h exp 1ab", o_rdata); end
    i_addr = 11'h7F9;
    cyc();
    idle();
    checks++;
    if (o_rdata !== 9'h03C) begin errors++; $display("FAIL b2b_sw: got %h exp 03c", o_rdata); end
  endtask

  task automatic test_tick_wrap();
    logic [8:0] t0, t1;
    rd(11'h7FC);
    t0 = o_rdata;
    repeat (511) cyc();
    rd(11'h7FC);
    checks++;
    if (o_rdata !== t0) begin errors++; $display("FAIL tick_wrap: got %h exp %h", o_rdata, t0); end
    t1 = t0 + 9'd1;
    rd(11'h7FC);
    checks++;
    if (o_rdata !== t1) begin errors++; $display("FAIL tick_step: got %h exp %h", o_rdata, t1); end
  endtask

  task automatic test_async_reset();
    rd(11'd5);
    rd(11'h7F8);
    checks++;
    if (o_rdata !== 9'h055) begin errors++; $display("FAIL arst_pre: got %h exp 055", o_rdata); end
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_rdata !== 9'h1AB) begin errors++; $display("FAIL arst_rdata: got %h exp 1ab", o_rdata); end
    checks++;
    if (o_led !== 8'h99) begin errors++; $display("FAIL arst_led: got %h exp 99", o_led); end
    #2 i_rst = 1'b0;
    cyc();
    rd(11'h7F8);
    checks++;
    if (o_rdata !== 9'h099) begin errors++; $display("FAIL arst_led_rd: got %h exp 099", o_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    mem[5] = 9'h1AB;
    ram_rdata = 9'h000;
    i_btn = '0; i_sw = '0; i_addr = '0; i_wdata = '0;
    test_reset();
    test_window();
    test_debounce();
    test_edge_race();
    test_back_to_back();
    test_tick_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
